load_store_unit: RTL and testbench

- Sits directly upstream of the word-wide data memory.
- Takes byte-addressed load/store requests from the execute/memory stage and translates them into word accesses on the memory's cs/we/address/data_in port. It then extracts and extends the load result from the memory's registered data_out.
- Sub-word stores use a read-modify-write sequence, because the memory only writes whole words.
- Big-endian byte order (MIPS convention): byte offset 0 is bits [31:24].

---
 rtl/load_store_unit.sv | 156 +++++++++++++++
 tb/tb_load_store_unit.sv | 239 +++++++++++++++++++++++
 2 files changed

// File: rtl/load_store_unit.sv
// Byte-addressed load/store front end for a word-wide, registered-output data memory.
// Big-endian lanes; sub-word stores run as read-modify-write.
module load_store_unit #(
  parameter int DATA_WIDTH = 32,
  parameter int ADDR_WIDTH = 13
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_we,
  input  logic [1:0]            req_size,
  input  logic                  req_signed,
  input  logic [31:0]           req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_address,
  output logic                  mem_cs,
  output logic                  mem_we,
  output logic [DATA_WIDTH-1:0] mem_wdata,
  input  logic [DATA_WIDTH-1:0] mem_rdata
);

  // state | meaning
  // IDLE  | ready for a request
  // RD    | memory read cycle (load or RMW fetch)
  // CAP   | registered read data available: extract load or merge store lane
  // WR    | memory write cycle
  // ERR   | misaligned / illegal size, no memory access
  // RESP  | one-cycle completion pulse
  typedef enum logic [2:0] {IDLE, RD, CAP, WR, ERR, RESP} state_t;

  state_t                  state, state_next;
  logic                    we_q;
  logic [1:0]              size_q;
  logic                    signed_q;
  logic [ADDR_WIDTH+1:0]   addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic                    req_error;
  logic [7:0]              lane_byte;
  logic [15:0]             lane_half;
  logic [DATA_WIDTH-1:0]   load_value;
  logic [DATA_WIDTH-1:0]   merged;
  logic                    unused_addr_bits;

  // Address bits above the memory range wrap around and are deliberately dropped.
  assign unused_addr_bits = ^req_addr[31:ADDR_WIDTH+2];

  assign req_error = (req_size == 2'b11) ||
                     (req_size == 2'b01 && req_addr[0]) ||
                     (req_size == 2'b10 && req_addr[1:0] != 2'b00);

  always_comb begin
    state_next = state;
    case (state)
      IDLE: begin
        if (req_valid) begin
          if (req_error)                       state_next = ERR;
          else if (req_we && req_size == 2'b10) state_next = WR;
          else                                  state_next = RD;
        end
      end
      RD:      state_next = CAP;
      CAP:     state_next = we_q ? WR : RESP;
      WR:      state_next = RESP;
      ERR:     state_next = RESP;
      RESP:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    lane_byte = mem_rdata[7:0];
    case (addr_q[1:0])
      2'd0:    lane_byte = mem_rdata[31:24];
      2'd1:    lane_byte = mem_rdata[23:16];
      2'd2:    lane_byte = mem_rdata[15:8];
      default: lane_byte = mem_rdata[7:0];
    endcase
    lane_half = addr_q[1] ? mem_rdata[15:0] : mem_rdata[31:16];

    load_value = mem_rdata;
    if (size_q == 2'b00)
      load_value = {{24{signed_q & lane_byte[7]}}, lane_byte};
    else if (size_q == 2'b01)
      load_value = {{16{signed_q & lane_half[15]}}, lane_half};

    merged = mem_rdata;
    if (size_q == 2'b00) begin
      case (addr_q[1:0])
        2'd0:    merged[31:24] = wdata_q[7:0];
        2'd1:    merged[23:16] = wdata_q[7:0];
        2'd2:    merged[15:8]  = wdata_q[7:0];
        default: merged[7:0]   = wdata_q[7:0];
      endcase
    end else if (addr_q[1]) begin
      merged[15:0] = wdata_q[15:0];
    end else begin
      merged[31:16] = wdata_q[15:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      we_q       <= 1'b0;
      size_q     <= 2'b00;
      signed_q   <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      resp_rdata <= '0;
      resp_err   <= 1'b0;
    end else begin
      state <= state_next;
      case (state)
        IDLE: begin
          if (req_valid) begin
            we_q     <= req_we;
            size_q   <= req_size;
            signed_q <= req_signed;
            addr_q   <= req_addr[ADDR_WIDTH+1:0];
            wdata_q  <= req_wdata;
          end
        end
        CAP: begin
          // For stores wdata_q becomes the merged word driven during WR.
          if (we_q) begin
            wdata_q <= merged;
          end else begin
            resp_rdata <= load_value;
            resp_err   <= 1'b0;
          end
        end
        WR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b0;
        end
        ERR: begin
          resp_rdata <= '0;
          resp_err   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign req_ready   = (state == IDLE);
  assign resp_valid  = (state == RESP);
  assign mem_cs      = (state == RD) || (state == WR);
  assign mem_we      = (state == WR);
  assign mem_address = addr_q[ADDR_WIDTH+1:2];
  assign mem_wdata   = wdata_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Scoreboard bench for load_store_unit with a registered-output word memory model.
module tb_load_store_unit;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        req_valid = 1'b0;
  logic        req_ready;
  logic        req_we = 1'b0;
  logic [1:0]  req_size = 2'b00;
  logic        req_signed = 1'b0;
  logic [31:0] req_addr = '0;
  logic [31:0] req_wdata = '0;
  logic        resp_valid;
  logic [31:0] resp_rdata;
  logic        resp_err;
  logic [12:0] mem_address;
  logic        mem_cs;
  logic        mem_we;
  logic [31:0] mem_wdata;
  logic [31:0] mem_rdata = '0;

  load_store_unit #(.DATA_WIDTH(32), .ADDR_WIDTH(13)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_size(req_size), .req_signed(req_signed), .req_addr(req_addr),
    .req_wdata(req_wdata),
    .resp_valid(resp_valid), .resp_rdata(resp_rdata), .resp_err(resp_err),
    .mem_address(mem_address), .mem_cs(mem_cs), .mem_we(mem_we),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          acc;
  } exp_t;

  exp_t        sb[$];
  int          checks = 0;
  int          errors = 0;
  int          cyc = 0;
  int          wr_count = 0;
  int          cs_count = 0;
  logic [31:0] last_wdata = '0;
  logic [31:0] mem [0:8191];

  always @(posedge clk) cyc <= cyc + 1;

  // Memory model: write on cs&&we, otherwise registered read.
  always @(posedge clk) begin
    if (mem_cs) begin
      cs_count <= cs_count + 1;
      if (mem_we) begin
        mem[mem_address] <= mem_wdata;
        wr_count         <= wr_count + 1;
        last_wdata       <= mem_wdata;
      end else begin
        mem_rdata <= mem[mem_address];
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT presents a response.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (!reset && resp_valid) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_resp actual=1 expected=0 cyc=%0d", cyc);
        end else begin
          e = sb.pop_front();
          chk("resp_rdata", resp_rdata, e.rdata);
          chk("resp_err", {31'b0, resp_err}, {31'b0, e.err});
          chk("latency", 32'(cyc - e.acc + 1), 32'(e.lat));
        end
      end
    end
  end

  task automatic step();
    @(negedge clk);
    #1;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      step();
      n++;
    end
    if (sb.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL resp_timeout actual=%0d expected=0 pending", sb.size());
      sb.delete();
    end
  endtask

  task automatic issue(input logic we, input logic [1:0] size, input logic sgn,
                       input logic [31:0] addr, input logic [31:0] wdata,
                       input logic [31:0] exp_rdata, input logic exp_err, input int exp_lat);
    int n = 0;
    step();
    while (!req_ready && n < 50) begin
      step();
      n++;
    end
    if (!req_ready) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout actual=0 expected=1");
    end
    req_valid  = 1'b1;
    req_we     = we;
    req_size   = size;
    req_signed = sgn;
    req_addr   = addr;
    req_wdata  = wdata;
    sb.push_back('{exp_rdata, exp_err, exp_lat, cyc + 1});
    step();
    req_valid = 1'b0;
    drain();
  endtask

  initial begin
    int wc, cc, c;
    repeat (3) step();
    reset = 1'b0;
    step();

    chk("rst_req_ready", {31'b0, req_ready}, 32'd1);
    chk("rst_resp_valid", {31'b0, resp_valid}, 32'd0);
    chk("rst_mem_cs", {31'b0, mem_cs}, 32'd0);
    chk("rst_mem_we", {31'b0, mem_we}, 32'd0);
    chk("rst_mem_address", {19'b0, mem_address}, 32'd0);
    chk("rst_mem_wdata", mem_wdata, 32'd0);
    chk("rst_resp_rdata", resp_rdata, 32'd0);
    chk("rst_resp_err", {31'b0, resp_err}, 32'd0);

    // word store then load
    wc = wr_count;
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'hDEADBEEF, 32'h0, 1'b0, 2);
    chk("sw_mem4", mem[4], 32'hDEADBEEF);
    chk("sw_writes", 32'(wr_count - wc), 32'd1);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'hDEADBEEF, 1'b0, 3);

    // byte/half loads with extension
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h80FF7F01, 32'h0, 1'b0, 2);
    issue(1'b0, 2'b00, 1'b1, 32'h11, 32'h0, 32'hFFFFFFFF, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h10, 32'h0, 32'h00000080, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b1, 32'h12, 32'h0, 32'h0000007F, 1'b0, 3);
    issue(1'b0, 2'b00, 1'b0, 32'h13, 32'h0, 32'h00000001, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h12, 32'h0, 32'h00007F01, 1'b0, 3);
    issue(1'b0, 2'b01, 1'b1, 32'h10, 32'h0, 32'hFFFF80FF, 1'b0, 3);
    issue(1'b0, 2'b10, 1'b0, 32'h8010, 32'h0, 32'h80FF7F01, 1'b0, 3);

    // sub-word read-modify-write
    issue(1'b1, 2'b10, 1'b0, 32'h10, 32'h11223344, 32'h0, 1'b0, 2);
    wc = wr_count;
    cc = cs_count;
    issue(1'b1, 2'b00, 1'b0, 32'h12, 32'h000000AA, 32'h0, 1'b0, 4);
    chk("sb_wdata", last_wdata, 32'h1122AA44);
    chk("sb_writes", 32'(wr_count - wc), 32'd1);
    chk("sb_cs_cycles", 32'(cs_count - cc), 32'd2);
    issue(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, 32'h1122AA44, 1'b0, 3);
    issue(1'b1, 2'b01, 1'b0, 32'h10, 32'h1234BEEF, 32'h0, 1'b0, 4);
    chk("sh_mem4", mem[4], 32'hBEEFAA44);
    issue(1'b0, 2'b01, 1'b0, 32'h10, 32'h0, 32'h0000BEEF, 1'b0, 3);

    // errors: no memory cycle, rdata 0
    cc = cs_count;
    issue(1'b0, 2'b10, 1'b0, 32'h12, 32'h0, 32'h0, 1'b1, 2);
    issue(1'b1, 2'b01, 1'b0, 32'h11, 32'hFFFF, 32'h0, 1'b1, 2);
    issue(1'b0, 2'b11, 1'b0, 32'h10, 32'h0, 32'h0, 1'b1, 2);
    chk("err_cs_cycles", 32'(cs_count - cc), 32'd0);
    chk("err_mem4", mem[4], 32'hBEEFAA44);

    // reset during CAP of a sub-word store
    wc = wr_count;
    step();
    req_valid = 1'b1; req_we = 1'b1; req_size = 2'b00; req_signed = 1'b0;
    req_addr = 32'h13; req_wdata = 32'h55;
    step();
    req_valid = 1'b0;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    chk("rst_mid_ready", {31'b0, req_ready}, 32'd1);
    repeat (6) step();
    chk("rst_mid_writes", 32'(wr_count - wc), 32'd0);
    chk("rst_mid_mem4", mem[4], 32'hBEEFAA44);

    // back-to-back with req_valid held; address change during RD ignored
    issue(1'b1, 2'b10, 1'b0, 32'h20, 32'hC0DE8001, 32'h0, 1'b0, 2);
    step();
    c = cyc;
    req_valid = 1'b1; req_we = 1'b0; req_size = 2'b10; req_signed = 1'b0;
    req_addr = 32'h10; req_wdata = 32'h0;
    sb.push_back('{32'hBEEFAA44, 1'b0, 3, c + 1});
    sb.push_back('{32'hFFFF8001, 1'b0, 3, c + 5});
    step();
    req_size = 2'b01; req_signed = 1'b1; req_addr = 32'h22;
    chk("b2b_rd_addr", {19'b0, mem_address}, 32'd4);
    chk("b2b_rd_cs", {31'b0, mem_cs}, 32'd1);
    chk("b2b_ready_rd", {31'b0, req_ready}, 32'd0);
    step();
    chk("b2b_cap_addr", {19'b0, mem_address}, 32'd4);
    chk("b2b_ready_cap", {31'b0, req_ready}, 32'd0);
    step();
    chk("b2b_ready_resp", {31'b0, req_ready}, 32'd0);
    step();
    chk("b2b_ready_idle", {31'b0, req_ready}, 32'd1);
    step();
    req_valid = 1'b0;
    chk("b2b_second_addr", {19'b0, mem_address}, 32'd8);
    chk("b2b_second_ready", {31'b0, req_ready}, 32'd0);
    drain();
    repeat (3) step();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
